// File: rtl/dshot_ctrl_pkg.sv
// Shared state encoding, command codes and throttle limit for the DShot frame sequencer.
package dshot_ctrl_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    FAILSAFE = 2'd2
  } state_t;

  localparam logic [5:0] CMD_MOTOR_STOP    = 6'd0;
  localparam logic [5:0] CMD_BEEP_LAST     = 6'd5;
  localparam logic [5:0] CMD_SPIN_DIR_1    = 6'd7;
  localparam logic [5:0] CMD_SPIN_DIR_2    = 6'd8;
  localparam logic [5:0] CMD_3D_OFF        = 6'd9;
  localparam logic [5:0] CMD_3D_ON         = 6'd10;
  localparam logic [5:0] CMD_SAVE          = 6'd12;
  localparam logic [5:0] CMD_SPIN_NORMAL   = 6'd20;
  localparam logic [5:0] CMD_SPIN_REVERSED = 6'd21;

  localparam int DSHOT_MAX_THROTTLE = 1999;

  function automatic logic [10:0] clamp_throttle(input logic [10:0] s, input int max_thr);
    return (int'(s) > max_thr) ? 11'(max_thr) : s;
  endfunction

endpackage

// File: rtl/dshot_repeat_filter.sv
// Qualifies special commands: beeps fire on first sight, others after CMD_REPEATS identical frames.
// fire is combinational with the accepted strobe; exec/exec_code are registered one cycle later.
module dshot_repeat_filter
  import dshot_ctrl_pkg::*;
#(
  parameter int CMD_REPEATS = 6
) (
  input  logic       quarterClockOut,
  input  logic       reset,
  input  logic       accept,
  input  logic       is_cmd,
  input  logic [5:0] code,
  output logic       fire,
  output logic       exec,
  output logic [5:0] exec_code
);

  localparam int RW = $clog2(CMD_REPEATS + 1);

  logic [RW-1:0] cnt, cnt_n, need;
  logic [5:0]    last_code;
  logic          last_cmd, done, done_n, same;

  assign same = is_cmd && last_cmd && (code == last_code);
  assign need = (code <= CMD_BEEP_LAST) ? RW'(1) : RW'(CMD_REPEATS);

  always_comb begin
    cnt_n  = cnt;
    done_n = done;
    fire   = 1'b0;
    if (accept) begin
      if (!is_cmd) begin
        cnt_n  = '0;
        done_n = 1'b0;
      end else begin
        if (same) begin
          cnt_n = (cnt == RW'(CMD_REPEATS)) ? cnt : cnt + 1'b1;
        end else begin
          cnt_n  = RW'(1);
          done_n = 1'b0;
        end
        // done blocks re-execution for the rest of an identical run
        if ((code != CMD_MOTOR_STOP) && !done_n && (cnt_n >= need)) begin
          fire   = 1'b1;
          done_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge quarterClockOut) begin
    if (reset) begin
      cnt       <= '0;
      done      <= 1'b0;
      last_cmd  <= 1'b0;
      last_code <= '0;
      exec      <= 1'b0;
      exec_code <= '0;
    end else begin
      cnt  <= cnt_n;
      done <= done_n;
      exec <= fire;
      if (accept) begin
        last_cmd  <= is_cmd;
        last_code <= code;
      end
      if (fire) exec_code <= code;
    end
  end

endmodule

// File: rtl/dshot_command_controller.sv
// Arming / failsafe / command sequencer after the DShot decoder; outputs update one cycle after a strobe.
// Optional bidirectional throttle mapping is enabled by defining DSHOT_3D_MODE_EN.
module dshot_command_controller
  import dshot_ctrl_pkg::*;
#(
  parameter int ARM_FRAMES    = 10,
  parameter int CMD_REPEATS   = 6,
  parameter int TIMEOUT_TICKS = 60000,
  parameter int MAX_THROTTLE  = DSHOT_MAX_THROTTLE
) (
  input  logic        quarterClockOut,
  input  logic        reset,
  input  logic        frame_strobe,
  input  logic        CRCValid,
  input  logic        isSpecialCommand,
  input  logic [5:0]  specialCommand,
  input  logic [10:0] setSpeed,
  output logic        armed,
  output logic [10:0] throttle,
  output logic        reversed,
  output logic        failsafe,
  output logic        cmd_exec,
  output logic [5:0]  cmd_code,
  output logic [1:0]  state_o
);

  localparam int AW = $clog2(ARM_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_t        state, state_n, eval_state;
  logic [AW-1:0] arm_cnt, arm_cnt_n;
  logic [TW-1:0] timer, timer_n;
  logic [10:0]   thr, thr_n;
  logic          rev, rev_n;
  logic          accepted, motor_stop, expire, fire;
  logic          flip;

  assign accepted   = frame_strobe && CRCValid;
  assign motor_stop = accepted && isSpecialCommand && (specialCommand == CMD_MOTOR_STOP);
  // expiry lands on the TIMEOUT_TICKS-th idle edge; an accepted frame that cycle wins
  assign expire     = !accepted && (timer >= TW'(TIMEOUT_TICKS - 1));

  dshot_repeat_filter #(.CMD_REPEATS(CMD_REPEATS)) u_repeat (
    .quarterClockOut (quarterClockOut),
    .reset           (reset),
    .accept          (accepted),
    .is_cmd          (isSpecialCommand),
    .code            (specialCommand),
    .fire            (fire),
    .exec            (cmd_exec),
    .exec_code       (cmd_code)
  );

`ifdef DSHOT_3D_MODE_EN
  logic mode_3d, mode_3d_n, flip_n;
`else
  assign flip = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    arm_cnt_n  = arm_cnt;
    thr_n      = thr;
    rev_n      = rev;
    timer_n    = (timer == TW'(TIMEOUT_TICKS)) ? timer : timer + 1'b1;
    eval_state = (state == FAILSAFE) ? DISARMED : state;
`ifdef DSHOT_3D_MODE_EN
    mode_3d_n  = mode_3d;
    flip_n     = flip;
`endif
    if (accepted) begin
      timer_n = '0;
      state_n = eval_state;
      case (eval_state)
        DISARMED: begin
          thr_n = '0;
          if (!motor_stop) begin
            arm_cnt_n = '0;
          end else if (arm_cnt >= AW'(ARM_FRAMES - 1)) begin
            arm_cnt_n = '0;
            state_n   = ARMED;
          end else begin
            arm_cnt_n = arm_cnt + 1'b1;
          end
        end
        ARMED: begin
          if (isSpecialCommand) thr_n = '0;
`ifdef DSHOT_3D_MODE_EN
          else if (mode_3d) begin
            flip_n = (setSpeed < 11'd1000);
            thr_n  = flip_n ? setSpeed : setSpeed - 11'd1000;
          end
`endif
          else thr_n = clamp_throttle(setSpeed, MAX_THROTTLE);
        end
        default: thr_n = '0;
      endcase
    end else if (expire && (state != FAILSAFE)) begin
      state_n   = FAILSAFE;
      arm_cnt_n = '0;
      thr_n     = '0;
`ifdef DSHOT_3D_MODE_EN
      flip_n    = 1'b0;
`endif
    end

    if (fire) begin
      case (specialCommand)
        CMD_SPIN_DIR_1, CMD_SPIN_NORMAL:   rev_n = 1'b0;
        CMD_SPIN_DIR_2, CMD_SPIN_REVERSED: rev_n = 1'b1;
`ifdef DSHOT_3D_MODE_EN
        CMD_3D_ON:  mode_3d_n = 1'b1;
        CMD_3D_OFF: begin
          mode_3d_n = 1'b0;
          flip_n    = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge quarterClockOut) begin
    if (reset) begin
      state   <= DISARMED;
      arm_cnt <= '0;
      timer   <= '0;
      thr     <= '0;
      rev     <= 1'b0;
`ifdef DSHOT_3D_MODE_EN
      mode_3d <= 1'b0;
      flip    <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      arm_cnt <= arm_cnt_n;
      timer   <= timer_n;
      thr     <= thr_n;
      rev     <= rev_n;
`ifdef DSHOT_3D_MODE_EN
      mode_3d <= mode_3d_n;
      flip    <= flip_n;
`endif
    end
  end

  assign armed    = (state == ARMED);
  assign failsafe = (state == FAILSAFE);
  assign throttle = thr;
  assign reversed = rev ^ flip;
  assign state_o  = state;

endmodule

// File: tb/tb_dshot_command_controller.sv
// Scoreboard bench: a frame-level reference model predicts outputs; a monitor compares after each strobe/probe.
module tb_dshot_command_controller;

  localparam int TO  = 300;
  localparam int ARM = 10;
  localparam int REP = 6;

  typedef struct packed {
    logic        armed;
    logic [10:0] thr;
    logic        rev;
    logic        fs;
    logic        exec;
    logic [5:0]  code;
    logic [1:0]  st;
  } obs_t;

  logic        clk;
  logic        reset, frame_strobe, CRCValid, isSpecialCommand;
  logic [5:0]  specialCommand;
  logic [10:0] setSpeed;
  logic        armed, reversed, failsafe, cmd_exec;
  logic [10:0] throttle;
  logic [5:0]  cmd_code;
  logic [1:0]  state_o;
  logic        probe, chk_now;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_cmp, n_bad;

  // reference model state
  int m_state, m_arm_run, m_thr, m_code, m_idle, run_len, run_code;
  bit m_rev, run_is_cmd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dshot_command_controller #(
    .ARM_FRAMES(ARM), .CMD_REPEATS(REP), .TIMEOUT_TICKS(TO), .MAX_THROTTLE(1999)
  ) dut (
    .quarterClockOut  (clk),
    .reset            (reset),
    .frame_strobe     (frame_strobe),
    .CRCValid         (CRCValid),
    .isSpecialCommand (isSpecialCommand),
    .specialCommand   (specialCommand),
    .setSpeed         (setSpeed),
    .armed            (armed),
    .throttle         (throttle),
    .reversed         (reversed),
    .failsafe         (failsafe),
    .cmd_exec         (cmd_exec),
    .cmd_code         (cmd_code),
    .state_o          (state_o)
  );

  task automatic model_reset();
    m_state = 0; m_arm_run = 0; m_thr = 0; m_code = 0; m_idle = 0;
    m_rev = 0; run_len = 0; run_code = 0; run_is_cmd = 0;
  endtask

  task automatic model_edge(input bit acc, input bit isc, input int code, input int spd,
                            output bit ex);
    ex = 0;
    if (!acc) begin
      m_idle++;
      if (m_idle == TO && m_state != 2) begin
        m_state = 2; m_thr = 0; m_arm_run = 0;
      end
    end else begin
      m_idle = 0;
      if (m_state == 2) begin
        m_state = 0; m_arm_run = 0;
      end
      if (isc && run_is_cmd && code == run_code) run_len++;
      else run_len = isc ? 1 : 0;
      run_is_cmd = isc;
      run_code   = code;
      ex = isc && code != 0 && run_len == ((code <= 5) ? 1 : REP);
      if (ex) begin
        m_code = code;
        if (code == 7 || code == 20) m_rev = 0;
        if (code == 8 || code == 21) m_rev = 1;
      end
      if (m_state == 0) begin
        m_thr = 0;
        if (isc && code == 0) begin
          m_arm_run++;
          if (m_arm_run == ARM) begin m_state = 1; m_arm_run = 0; end
        end else m_arm_run = 0;
      end else begin
        m_thr = isc ? 0 : ((spd > 1999) ? 1999 : spd);
      end
    end
  endtask

  task automatic push(input string nm, input bit ex);
    obs_t o;
    o.armed = (m_state == 1);
    o.thr   = 11'(m_thr);
    o.rev   = m_rev;
    o.fs    = (m_state == 2);
    o.exec  = ex;
    o.code  = 6'(m_code);
    o.st    = 2'(m_state);
    exp_q.push_back(o);
    name_q.push_back(nm);
  endtask

  // one clock edge; the expected outputs after that edge are queued when checked
  task automatic step(input bit stb, input bit crc, input bit isc, input int code,
                      input int spd, input bit prb, input string nm);
    bit ex;
    frame_strobe = stb; CRCValid = crc; isSpecialCommand = isc;
    specialCommand = 6'(code); setSpeed = 11'(spd); probe = prb;
    @(posedge clk); #1;
    ex = 0;
    if (reset) model_reset();
    else model_edge(stb && crc, isc, code, spd, ex);
    if (stb || prb) push(nm, ex);
    frame_strobe = 0; CRCValid = 0; probe = 0;
  endtask

  task automatic stop_f(input string nm);                 step(1, 1, 1, 0, 0, 0, nm); endtask
  task automatic spd_f(input int s, input string nm);     step(1, 1, 0, 0, s, 0, nm); endtask
  task automatic cmd_f(input int c, input bit crc, input string nm); step(1, crc, 1, c, 0, 0, nm); endtask
  task automatic idle(input int n, input bit prb, input string nm);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, prb && (i == n - 1), nm);
  endtask
  task automatic do_reset();
    reset = 1; step(0, 0, 0, 0, 0, 1, "reset_state"); reset = 0;
  endtask

  always @(posedge clk) chk_now <= frame_strobe || probe;

  always @(negedge clk) begin
    obs_t a, e;
    string nm;
    if (chk_now) begin
      n_cmp++;
      a = '{armed, throttle, reversed, failsafe, cmd_exec, cmd_code, state_o};
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL underflow: output sampled with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s @%0t: got armed=%0b thr=%0d rev=%0b fs=%0b exec=%0b code=%0d st=%0d, want armed=%0b thr=%0d rev=%0b fs=%0b exec=%0b code=%0d st=%0d",
                   nm, $time, a.armed, a.thr, a.rev, a.fs, a.exec, a.code, a.st,
                   e.armed, e.thr, e.rev, e.fs, e.exec, e.code, e.st);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int codes[12];
    int speeds[8];
    codes  = '{1, 3, 5, 7, 8, 9, 10, 12, 20, 21, 30, 47};
    speeds = '{0, 1, 999, 1000, 1998, 1999, 2000, 2047};
    n_cmp = 0; n_bad = 0; chk_now = 0;
    reset = 1; frame_strobe = 0; CRCValid = 0; isSpecialCommand = 0;
    specialCommand = '0; setSpeed = '0; probe = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    do_reset();

    // arming: ten stops arm; a speed frame in the middle restarts the count
    for (int i = 0; i < ARM; i++) stop_f("arm10");
    do_reset();
    for (int i = 0; i < 9; i++) stop_f("arm9a");
    spd_f(700, "arm_break");
    for (int i = 0; i < 9; i++) stop_f("arm9b");
    stop_f("arm_after_break");
    spd_f(1500, "thr1500");
    spd_f(2047, "thr_clamp");

    // timeout boundary: frame on the expiry cycle wins, then a real expiry
    idle(TO - 1, 1, "pre_expiry");
    spd_f(1000, "frame_at_expiry");
    idle(TO - 1, 1, "pre_expiry2");
    idle(1, 1, "failsafe");
    stop_f("fs_exit");
    for (int i = 0; i < ARM - 1; i++) stop_f("rearm");

    // command repeat qualification and direction
    for (int i = 0; i < REP + 1; i++) cmd_f(21, 1, "cmd21_x7");
    spd_f(500, "cmd_break");
    for (int i = 0; i < 5; i++) cmd_f(21, 1, "cmd21_x5a");
    cmd_f(20, 1, "cmd20_single");
    for (int i = 0; i < 5; i++) cmd_f(21, 1, "cmd21_x5b");
    for (int i = 0; i < REP; i++) cmd_f(20, 1, "cmd20_x6");
    for (int i = 0; i < REP; i++) begin
      cmd_f(21, 0, "cmd21_badcrc");
      cmd_f(21, 1, "cmd21_interleaved");
    end
    cmd_f(3, 1, "beep3");
    cmd_f(3, 1, "beep3_again");

    // reset beats a simultaneous strobe
    spd_f(800, "thr800");
    reset = 1;
    step(1, 1, 0, 0, 1200, 0, "reset_with_strobe");
    reset = 0;

    // randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int b = 0; b < 300; b++) begin
        int kind, len, code, spd;
        kind = $urandom_range(0, 9);
        len  = (kind < 4) ? $urandom_range(1, 12) : $urandom_range(1, 8);
        code = codes[$urandom_range(0, 11)];
        spd  = ($urandom_range(0, 1) == 0) ? speeds[$urandom_range(0, 7)] : $urandom_range(0, 2047);
        for (int k = 0; k < len; k++) begin
          bit crc;
          crc = ($urandom_range(0, 7) != 0);
          if (kind < 4)      step(1, crc, 1, 0, 0, 0, "rnd_stop");
          else if (kind < 6) step(1, crc, 0, 0, spd, 0, "rnd_speed");
          else               step(1, crc, 1, code, 0, 0, "rnd_cmd");
          idle($urandom_range(0, 2), 0, "rnd_gap");
        end
        if ($urandom_range(0, 39) == 0) idle($urandom_range(TO - 2, TO + 2), 1, "rnd_long_idle");
      end
    end

    idle(3, 0, "drain");
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
